// File: rtl/wb_regfile_if.sv
// Writeback bus bundle: MEM/WB inputs, ID read ports and
// EX forwarding selects, shared by the WB stage and its driver.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [1:0]        wb_ctrl;
  logic [DATA_W-1:0] mem_dout;
  logic [DATA_W-1:0] alu_out;
  logic [ADDR_W-1:0] rd_wb;
  logic [ADDR_W-1:0] ra_addr;
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] ra_data;
  logic [DATA_W-1:0] rb_data;
  logic [DATA_W-1:0] wb_data;
  logic              exm_regwrite;
  logic [ADDR_W-1:0] exm_rd;
  logic [ADDR_W-1:0] idex_rs;
  logic [ADDR_W-1:0] idex_rt;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;

  modport master (
    output wb_ctrl, mem_dout, alu_out, rd_wb,
    output ra_addr, rb_addr,
    output exm_regwrite, exm_rd, idex_rs, idex_rt,
    input  ra_data, rb_data, wb_data, fwd_a, fwd_b
  );

  modport slave (
    input  wb_ctrl, mem_dout, alu_out, rd_wb,
    input  ra_addr, rb_addr,
    input  exm_regwrite, exm_rd, idex_rs, idex_rt,
    output ra_data, rb_data, wb_data, fwd_a, fwd_b
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage: result mux, 32-entry register file with
// write-through read ports, and EX operand forwarding selects.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic         clk,
  input logic         reset,
  wb_regfile_if.slave bus
);
  localparam int N = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [N];
  logic [DATA_W-1:0] w_wb_data;
  logic [DATA_W-1:0] w_ra_data;
  logic [DATA_W-1:0] w_rb_data;
  logic              w_wb_valid;
  logic              w_exm_valid;
  logic              w_we;
  logic [1:0]        w_fwd_a;
  logic [1:0]        w_fwd_b;

  assign w_wb_data = bus.wb_ctrl[0] ? bus.mem_dout
                                    : bus.alu_out;
  assign w_wb_valid  = bus.wb_ctrl[1] & (bus.rd_wb != '0);
  assign w_exm_valid = bus.exm_regwrite
                     & (bus.exm_rd != '0);
  assign w_we = w_wb_valid & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) r_mem[i] <= '0;
    end else if (w_we) begin
      r_mem[bus.rd_wb] <= w_wb_data;
    end
  end

  // Reg 0 reads zero even though its storage is never written
  always_comb begin
    w_ra_data = r_mem[bus.ra_addr];
    if (reset || bus.ra_addr == '0)
      w_ra_data = '0;
    else if (w_we && bus.ra_addr == bus.rd_wb)
      w_ra_data = w_wb_data;
  end

  always_comb begin
    w_rb_data = r_mem[bus.rb_addr];
    if (reset || bus.rb_addr == '0)
      w_rb_data = '0;
    else if (w_we && bus.rb_addr == bus.rd_wb)
      w_rb_data = w_wb_data;
  end

  // EX/MEM checked first: it holds the newer value
  always_comb begin
    w_fwd_a = 2'b00;
    if (!reset) begin
      if (w_exm_valid && bus.exm_rd == bus.idex_rs)
        w_fwd_a = 2'b10;
      else if (w_wb_valid && bus.rd_wb == bus.idex_rs)
        w_fwd_a = 2'b01;
    end
  end

  always_comb begin
    w_fwd_b = 2'b00;
    if (!reset) begin
      if (w_exm_valid && bus.exm_rd == bus.idex_rt)
        w_fwd_b = 2'b10;
      else if (w_wb_valid && bus.rd_wb == bus.idex_rt)
        w_fwd_b = 2'b01;
    end
  end

  assign bus.wb_data = w_wb_data;
  assign bus.ra_data = w_ra_data;
  assign bus.rb_data = w_rb_data;
  assign bus.fwd_a   = w_fwd_a;
  assign bus.fwd_b   = w_fwd_b;
endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-stage consumer of the MEM/WB pipeline register. Selects the writeback value (memory data or ALU result) from the registered MEM/WB control bits, writes it into a 32 x 32-bit register file, and serves two asynchronous read ports for the ID stage with same-cycle write-through bypass. Also produces EX-stage forwarding selects from the EX/MEM and MEM/WB destination tags, closing the loop on the data the MEM/WB register launches.

## Interface
Parameters
- DATA_W, 32, register and datapath width
- ADDR_W, 5, register index width (2**ADDR_W registers)

Ports
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- wb_ctrl  in  2  MEM/WB control: [1] = RegWrite, [0] = MemtoReg
- mem_dout  in  DATA_W  MEM/WB registered load data
- alu_out  in  DATA_W  MEM/WB registered ALU result
- rd_wb  in  ADDR_W  MEM/WB destination register
- ra_addr, rb_addr  in  ADDR_W  ID-stage read addresses (rs, rt)
- ra_data, rb_data  out  DATA_W  ID-stage read data
- wb_data  out  DATA_W  selected writeback value
- exm_regwrite  in  1  EX/MEM RegWrite
- exm_rd  in  ADDR_W  EX/MEM destination register
- idex_rs, idex_rt  in  ADDR_W  ID/EX source registers
- fwd_a, fwd_b  out  2  EX operand select: 00 register file, 10 EX/MEM ALU, 01 MEM/WB wb_data

## Operation
- wb_data = wb_ctrl[0] ? mem_dout : alu_out (combinational, independent of RegWrite).
- Write enable we = wb_ctrl[1] & (rd_wb != 0) & ~reset.
- Register 0 hardwired to zero: never written, always reads 0.
- Read port X (A or B): if reset, 0; else if addr == 0, 0; else if we and addr == rd_wb, wb_data (bypass); else array[addr].
- Both ports may read the same address; both return identical values, including bypass.
- Forwarding, per operand (rs -> fwd_a, rt -> fwd_b):
  - 10 if exm_regwrite and exm_rd != 0 and exm_rd == src.
  - else 01 if wb_ctrl[1] and rd_wb != 0 and rd_wb == src.
  - else 00.
  - EX/MEM has priority over MEM/WB when both match (newest value wins).
  - Forced to 00 while reset is high.
- Reset: on a rising edge with reset high, all 32 entries clear to 0; any pending write in that cycle is discarded.

## Timing
- Write latency: value presented on cycle N (we=1) is in the array after edge N; visible on read ports in cycle N via bypass and from cycle N+1 via the array.
- Reads, wb_data, fwd_a/fwd_b are purely combinational from current inputs and array state; no read latency.
- Reset values: array all 0; ra_data, rb_data, fwd_a, fwd_b = 0 during and after reset until a write occurs; wb_data follows inputs (not gated by reset).
- Reset asserted mid-stream: the write on the reset edge is suppressed; the first write accepted is on the first edge with reset low.
- Write to rd_wb = 0 with RegWrite = 1: no state change, no bypass, no MEM/WB forward.
- Back-to-back writes to the same register: last edge wins; bypass always reflects the current cycle's wb_data.

## Test plan
- Reset: preload r5=0x1234 via write, assert reset 1 cycle -> ra_addr=5 reads 0x00000000 next cycle; fwd_a=fwd_b=00 while reset high.
- Mux/write: wb_ctrl=2'b11, mem_dout=0xDEADBEEF, alu_out=0x11111111, rd_wb=7; next cycle wb_ctrl=2'b10, alu_out=0x22222222, rd_wb=8 -> r7=0xDEADBEEF, r8=0x22222222 on later reads.
- Bypass: wb_ctrl=2'b10, alu_out=0xCAFEF00D, rd_wb=3, ra_addr=rb_addr=3 same cycle -> ra_data=rb_data=0xCAFEF00D before the edge.
- Zero register: wb_ctrl=2'b10, rd_wb=0, alu_out=0xFFFFFFFF, ra_addr=0 -> ra_data=0 same and next cycle; fwd_a=00 with idex_rs=0.
- Forward priority: exm_regwrite=1, exm_rd=4, wb_ctrl[1]=1, rd_wb=4, idex_rs=4, idex_rt=9 -> fwd_a=10, fwd_b=00; then exm_regwrite=0 -> fwd_a=01.
- Reset mid-write: wb_ctrl=2'b10, rd_wb=6, alu_out=0x55 with reset high on that edge -> r6 reads 0 after reset deasserts.
